// File: rtl/spram_pkg.sv
// Shared constants and types for the single-port RAM arbiter.
//
// Contents:
//   DATA_WIDTH  - RAM word width
//   RAM_DEPTH   - number of RAM words
//   ADDR_WIDTH  - RAM address width, derived from RAM_DEPTH
//   addr_t      - RAM address type
//   data_t      - RAM data word type
package spram_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int RAM_DEPTH  = 8;
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : spram_pkg

// File: rtl/spram_arbiter_if.sv
// Bundle of every signal the arbiter exchanges with its clients and with the
// RAM instance. Signal names keep the arbiter's point of view (_ip = into the
// arbiter, _op = out of the arbiter).
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding logic (requesters plus the RAM)
//
// Signals:
//   req_ip        NUM_REQ              per-requester access request
//   we_ip         NUM_REQ              per-requester write(1)/read(0)
//   address_ip    NUM_REQ*ADDR_WIDTH   packed addresses, requester i at slice i
//   data_ip       NUM_REQ*DATA_WIDTH   packed write data, requester i at slice i
//   gnt_op        NUM_REQ              one-hot grant, same cycle as the access
//   rvalid_op     NUM_REQ              one-hot read-data-valid strobe
//   rdata_op      DATA_WIDTH           read data broadcast to all requesters
//   ram_we_op     1                    RAM write enable
//   ram_address_op ADDR_WIDTH          RAM address
//   ram_data_op   DATA_WIDTH           RAM write data
//   ram_rdata_ip  DATA_WIDTH           RAM read data, one cycle after address
interface spram_arbiter_if
    import spram_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]            req_ip;
    logic [NUM_REQ-1:0]            we_ip;
    logic [NUM_REQ*ADDR_WIDTH-1:0] address_ip;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_ip;
    logic [NUM_REQ-1:0]            gnt_op;
    logic [NUM_REQ-1:0]            rvalid_op;
    data_t                         rdata_op;
    logic                          ram_we_op;
    addr_t                         ram_address_op;
    data_t                         ram_data_op;
    data_t                         ram_rdata_ip;

    modport slave (
        input  req_ip,
        input  we_ip,
        input  address_ip,
        input  data_ip,
        input  ram_rdata_ip,
        output gnt_op,
        output rvalid_op,
        output rdata_op,
        output ram_we_op,
        output ram_address_op,
        output ram_data_op
    );

    modport master (
        output req_ip,
        output we_ip,
        output address_ip,
        output data_ip,
        output ram_rdata_ip,
        input  gnt_op,
        input  rvalid_op,
        input  rdata_op,
        input  ram_we_op,
        input  ram_address_op,
        input  ram_data_op
    );

endinterface : spram_arbiter_if

// File: rtl/spram_arbiter_rr_pick.sv
// Purely combinational round-robin picker.
//
// Searches the request vector starting at start_idx and wrapping modulo
// NUM_REQ; the first set request wins.
//
// Ports:
//   req         in   NUM_REQ  request vector
//   start_idx   in   IDXW     first index to examine
//   win_onehot  out  NUM_REQ  one-hot winner (all zero when nothing requests)
//   win_idx     out  IDXW     winner index (0 when nothing requests)
//   win_any     out  1        at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    start_idx,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDXW-1:0]    win_idx,
    output logic               win_any
);

    // cand_idx[k] is the requester examined k-th in the search order.
    logic [IDXW-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDXW:0] sum;
            logic [IDXW:0] sum_wrapped;
            assign sum         = {1'b0, start_idx} + (IDXW+1)'(gi);
            assign sum_wrapped = sum - (IDXW+1)'(NUM_REQ);
            assign cand_idx[gi] = (sum >= (IDXW+1)'(NUM_REQ)) ? sum_wrapped[IDXW-1:0]
                                                              : sum[IDXW-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Walk from the last candidate to the first so the earliest set
    // candidate in search order is the one left standing.
    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_any = 1'b1;
                win_idx = cand_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = win_any && (win_idx == IDXW'(gi));
        end
    endgenerate

endmodule : rr_pick

// File: rtl/spram_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ requesters.
//
// Round-robin arbitration with a bounded burst: the current owner keeps the
// RAM while it keeps requesting, for up to MAX_BURST consecutive grants when
// someone else is waiting; a lone requester is never forced to yield. The
// grant and the RAM access are issued combinationally in the same cycle, and
// read data returns one cycle later with a one-hot valid strobe.
//
// Ports:
//   clk_ip  in   1  clock, all state changes on the rising edge
//   rst_ip  in   1  synchronous active-high reset
//   bus     slave modport of spram_arbiter_if (requester and RAM signals)
//
// Parameters:
//   NUM_REQ   number of requesters, 2..4
//   MAX_BURST maximum consecutive grants to one owner while others wait, >=1
module spram_arbiter
    import spram_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic            clk_ip,
    input  logic            rst_ip,
    spram_arbiter_if.slave  bus
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef logic [IDXW-1:0] idx_t;
    typedef logic [CNTW-1:0] cnt_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_REQ - 1);
    localparam cnt_t BURST_MAX = cnt_t'(MAX_BURST);

    // Registered arbitration state.
    logic               owner_valid_reg;
    idx_t               last_owner_reg;
    cnt_t               burst_cnt_reg;
    logic [NUM_REQ-1:0] rvalid_reg;

    // Per-requester views of the packed buses.
    addr_t              addr_slice [NUM_REQ];
    data_t              data_slice [NUM_REQ];

    // Arbitration decision for the current cycle.
    idx_t               start_idx;
    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] others_req;
    logic               keep_owner;
    logic [NUM_REQ-1:0] pick_onehot;
    idx_t               pick_idx;
    logic               pick_any;
    idx_t               win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               issue;
    logic               same_owner;
    cnt_t               burst_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_slice[gi] = bus.address_ip[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_slice[gi] = bus.data_ip[gi*DATA_WIDTH +: DATA_WIDTH];
            assign owner_mask[gi] = (last_owner_reg == idx_t'(gi));
        end
    endgenerate

    // The search begins just after the previous owner so it is examined last.
    assign start_idx = (last_owner_reg == LAST_IDX) ? '0 : idx_t'(last_owner_reg + 1'b1);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_pick (
        .req        (bus.req_ip),
        .start_idx  (start_idx),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_any    (pick_any)
    );

    assign others_req = bus.req_ip & ~owner_mask;

    // The owner only has to give way once its burst is used up AND somebody
    // else is actually waiting.
    assign keep_owner = owner_valid_reg
                      && (|(bus.req_ip & owner_mask))
                      && ((burst_cnt_reg < BURST_MAX) || !(|others_req));

    assign win_idx    = keep_owner ? last_owner_reg : pick_idx;
    assign win_onehot = rst_ip ? '0 : (keep_owner ? owner_mask : pick_onehot);
    assign issue      = |win_onehot;

    // Grant and RAM access go out in the same cycle.
    assign bus.gnt_op         = win_onehot;
    assign bus.ram_we_op      = issue && bus.we_ip[win_idx];
    assign bus.ram_address_op = addr_slice[win_idx];
    assign bus.ram_data_op    = data_slice[win_idx];

    // Read return: the RAM output is broadcast, the strobe says whose it is.
    // The strobe is masked during reset so a read issued just before reset
    // never reports.
    assign bus.rvalid_op = rst_ip ? '0 : rvalid_reg;
    assign bus.rdata_op  = bus.ram_rdata_ip;

    assign same_owner     = owner_valid_reg && (win_idx == last_owner_reg);
    assign burst_cnt_next = !same_owner               ? cnt_t'(1) :
                            (burst_cnt_reg == BURST_MAX) ? burst_cnt_reg :
                                                        cnt_t'(burst_cnt_reg + 1'b1);

    always_ff @(posedge clk_ip) begin
        if (rst_ip) begin
            owner_valid_reg <= 1'b0;
            last_owner_reg  <= LAST_IDX;
            burst_cnt_reg   <= '0;
            rvalid_reg      <= '0;
        end else if (issue) begin
            owner_valid_reg <= 1'b1;
            last_owner_reg  <= win_idx;
            burst_cnt_reg   <= burst_cnt_next;
            rvalid_reg      <= bus.ram_we_op ? '0 : win_onehot;
        end else begin
            owner_valid_reg <= 1'b0;
            burst_cnt_reg   <= '0;
            rvalid_reg      <= '0;
        end
    end

endmodule : spram_arbiter
